// File: rtl/ifetch_pkg.sv
// Shared widths, RV32 opcode constants, fetch-queue entry type and immediate helpers
// for the instruction-fetch front end.
package ifetch_pkg;

  localparam int ADDR_WID = 32;
  localparam int INST_WID = 32;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  localparam logic [6:0] OPCODE_B   = 7'b1100011;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FETCH = 1'b1;

  typedef struct packed {
    logic [INST_WID-1:0] inst;
    logic [ADDR_WID-1:0] pc;
    logic                pre_j;
  } fq_entry_t;

  function automatic logic [ADDR_WID-1:0] imm_j(input logic [INST_WID-1:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [ADDR_WID-1:0] imm_b(input logic [INST_WID-1:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  // Two-bit saturating counter step.
  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/ifetch_unit_icache.sv
// Set-associative ICache storage: combinational lookup on the fetch pc and a
// registered line-fill port with invalid-first / LRU victim choice.
module icache_array
  import ifetch_pkg::*;
#(
  parameter int SETS       = 32,
  parameter int WAYS       = 2,
  parameter int LINE_INSTS = 8
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic [ADDR_WID-1:0]          lookup_pc,
  input  logic                         touch,
  input  logic                         fill_en,
  input  logic [ADDR_WID-1:0]          fill_pc,
  input  logic [INST_WID*LINE_INSTS-1:0] fill_line,
  output logic                         hit,
  output logic [INST_WID-1:0]          hit_inst
);
  localparam int OFF   = $clog2(LINE_INSTS) + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int WRD_W = $clog2(LINE_INSTS);
  localparam int TAG_W = ADDR_WID - IDX_W - OFF;

  logic [SETS-1:0][WAYS-1:0] valid;
  logic [SETS-1:0]           lru;
  logic [TAG_W-1:0]          tags  [SETS][WAYS];
  logic [LINE_INSTS-1:0][INST_WID-1:0] lines [SETS][WAYS];

  logic [IDX_W-1:0] l_idx, f_idx;
  logic [TAG_W-1:0] l_tag;
  logic [WRD_W-1:0] l_wrd;
  logic             hit_way, f_way;

  assign l_idx = lookup_pc[OFF +: IDX_W];
  assign l_tag = lookup_pc[ADDR_WID-1 -: TAG_W];
  assign l_wrd = lookup_pc[2 +: WRD_W];
  assign f_idx = fill_pc[OFF +: IDX_W];

  // Scan high way to low so way 0 wins if a tag ever sits in both ways.
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[l_idx][w] && tags[l_idx][w] == l_tag) begin
        hit     = 1'b1;
        hit_way = w[0];
      end
    end
    hit_inst = lines[l_idx][hit_way][l_wrd];
  end

  always_comb begin
    if (!valid[f_idx][0])                       f_way = 1'b0;
    else if (WAYS > 1 && !valid[f_idx][WAYS-1]) f_way = 1'b1;
    else                                        f_way = (WAYS > 1) ? lru[f_idx] : 1'b0;
  end

  // A fill to the same set as a concurrent hit takes precedence on the LRU bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      lru   <= '0;
    end else if (rdy) begin
      if (touch && hit) lru[l_idx] <= ~hit_way;
      if (fill_en) begin
        valid[f_idx][f_way] <= 1'b1;
        lru[f_idx]          <= ~f_way;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_en) begin
      tags[f_idx][f_way]  <= fill_pc[ADDR_WID-1 -: TAG_W];
      lines[f_idx][f_way] <= fill_line;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], fill_pc[OFF-1:0]};

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front end: ICache lookup, bimodal/JAL next-pc prediction, fetch queue
// toward dispatch, line-refill FSM and RoB rollback / predictor training.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int SETS       = 32,
  parameter int WAYS       = 2,
  parameter int LINE_INSTS = 8,
  parameter int FQ_DEPTH   = 4,
  parameter int PRE_SIZE   = 1024
)(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           rollback,
  input  logic                           rs_full,
  input  logic                           lsb_full,
  input  logic                           rob_full,
  output logic                           mem_en,
  output logic [ADDR_WID-1:0]            mem_pc,
  input  logic                           mem_done,
  input  logic [INST_WID*LINE_INSTS-1:0] mem_data,
  output logic                           inst_done,
  output logic [INST_WID-1:0]            inst,
  output logic [ADDR_WID-1:0]            inst_pc,
  output logic                           inst_pre_j,
  input  logic                           br_pre,
  input  logic                           br_pre_j,
  input  logic [ADDR_WID-1:0]            br_pre_pc,
  input  logic [ADDR_WID-1:0]            br_res_pc
);
  localparam int OFF   = $clog2(LINE_INSTS) + 2;
  localparam int PI_W  = $clog2(PRE_SIZE);
  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WID-1:0]      pc, npc;
  logic [INST_WID-1:0]      hit_inst;
  logic                     hit, pre_j, pop, push, full, fill_en;
  logic [0:0]               state;
  logic [PRE_SIZE-1:0][1:0] cnt;
  logic [PI_W-1:0]          pre_idx, upd_idx;
  fq_entry_t                fq [FQ_DEPTH];
  logic [PTR_W-1:0]         head, tail;
  logic [CNT_W-1:0]         count;

  icache_array #(
    .SETS       (SETS),
    .WAYS       (WAYS),
    .LINE_INSTS (LINE_INSTS)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .lookup_pc (pc),
    .touch     (hit & ~rollback),
    .fill_en   (fill_en),
    .fill_pc   (mem_pc),
    .fill_line (mem_data),
    .hit       (hit),
    .hit_inst  (hit_inst)
  );

  assign pre_idx = pc[PI_W+1:2];
  assign upd_idx = br_pre_pc[PI_W+1:2];
  assign full    = (count == CNT_W'(FQ_DEPTH));
  assign pop     = (count != '0) && !rs_full && !lsb_full && !rob_full;
  assign push    = hit && (!full || pop) && !rollback;
  assign fill_en = (state == ST_FETCH) && mem_done;

  // JALR target is unknown here, so it falls through like any non-branch.
  always_comb begin
    pre_j = 1'b0;
    npc   = pc + 32'd4;
    if (hit_inst[6:0] == OPCODE_JAL) begin
      pre_j = 1'b1;
      npc   = pc + imm_j(hit_inst);
    end else if (hit_inst[6:0] == OPCODE_B && cnt[pre_idx][1]) begin
      pre_j = 1'b1;
      npc   = pc + imm_b(hit_inst);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && push) fq[tail] <= '{inst: hit_inst, pc: pc, pre_j: pre_j};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      inst_done  <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_pre_j <= 1'b0;
      cnt        <= {PRE_SIZE{2'b01}};
      state      <= ST_IDLE;
      mem_en     <= 1'b0;
      mem_pc     <= '0;
    end else if (rdy) begin
      if (br_pre) cnt[upd_idx] <= sat_upd(cnt[upd_idx], br_pre_j);

      if (rollback) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        inst_done <= 1'b0;
        pc        <= br_res_pc;
      end else begin
        inst_done <= pop;
        if (pop) begin
          inst       <= fq[head].inst;
          inst_pc    <= fq[head].pc;
          inst_pre_j <= fq[head].pre_j;
          head       <= head + 1'b1;
        end
        if (push) begin
          tail <= tail + 1'b1;
          pc   <= npc;
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end

      // An outstanding refill survives rollback; its line is still valid code.
      case (state)
        ST_IDLE: if (!hit && !rollback) begin
          state  <= ST_FETCH;
          mem_en <= 1'b1;
          mem_pc <= {pc[ADDR_WID-1:OFF], {OFF{1'b0}}};
        end
        ST_FETCH: if (mem_done) begin
          state  <= ST_IDLE;
          mem_en <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{br_pre_pc[ADDR_WID-1:PI_W+2], br_pre_pc[1:0]};

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: memory responder model, output monitor, and a
// linear sequence of phases with hand-derived expected streams.
module tb_ifetch_unit;
  localparam int LI = 8;

  logic clk = 1'b0;
  logic rst, rdy, rollback, rs_full, lsb_full, rob_full;
  logic mem_en, mem_done, inst_done, inst_pre_j, br_pre, br_pre_j;
  logic [31:0] mem_pc, inst, inst_pc, br_pre_pc, br_res_pc;
  logic [32*LI-1:0] mem_data;

  ifetch_unit #(.SETS(32), .WAYS(2), .LINE_INSTS(LI), .FQ_DEPTH(4), .PRE_SIZE(1024)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rs_full(rs_full),
    .lsb_full(lsb_full), .rob_full(rob_full), .mem_en(mem_en), .mem_pc(mem_pc),
    .mem_done(mem_done), .mem_data(mem_data), .inst_done(inst_done), .inst(inst),
    .inst_pc(inst_pc), .inst_pre_j(inst_pre_j), .br_pre(br_pre), .br_pre_j(br_pre_j),
    .br_pre_pc(br_pre_pc), .br_res_pc(br_res_pc)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, lat_cnt = 0, c0 = 0;
  bit mem_stall = 1'b0;
  logic [31:0] imem [0:1023];
  logic [31:0] obs_pc[$], obs_inst[$], refills[$];
  logic        obs_pj[$];
  int          obs_cyc[$];

  function automatic logic [31:0] addi(input logic [31:0] a);
    return {a[13:2], 5'd1, 3'd0, 5'd1, 7'h13};
  endfunction
  function automatic logic [31:0] jal(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction
  function automatic logic [31:0] beq(input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [32*LI-1:0] line_of(input logic [31:0] a);
    logic [32*LI-1:0] d;
    for (int k = 0; k < LI; k++) d[32*k +: 32] = imem[10'(a[11:2] + 10'(k))];
    return d;
  endfunction

  function automatic logic [31:0] opc(input int i);
    return (i < obs_pc.size()) ? obs_pc[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] oinst(input int i);
    return (i < obs_inst.size()) ? obs_inst[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] opj(input int i);
    return (i < obs_pj.size()) ? 32'(obs_pj[i]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] ocyc(input int i);
    return (i < obs_cyc.size()) ? 32'(obs_cyc[i]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] rfl(input int i);
    return (i < refills.size()) ? refills[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic wait_obs(input int n, input int budget, input string tag);
    int k = 0;
    while (obs_pc.size() < n && k < budget) begin @(negedge clk); k++; end
    chk(tag, 32'(obs_pc.size() >= n), 32'd1);
  endtask

  task automatic start_phase();
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    rob_full = 1'b0; br_pre = 1'b0; br_pre_j = 1'b0; br_pre_pc = '0; br_res_pc = '0;
    mem_stall = 1'b0;
    repeat (3) @(negedge clk);
    obs_pc.delete(); obs_inst.delete(); obs_pj.delete(); obs_cyc.delete(); refills.delete();
    for (int i = 0; i < 1024; i++) imem[i] = addi(32'(i * 4));
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (inst_done === 1'b1 && rst === 1'b0) begin
      obs_pc.push_back(inst_pc); obs_inst.push_back(inst);
      obs_pj.push_back(inst_pre_j); obs_cyc.push_back(cyc);
    end
  end

  // Memory model: answers a refill request after a short latency unless stalled.
  initial begin
    mem_done = 1'b0; mem_data = '0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (mem_en === 1'b1 && !mem_stall && rst === 1'b0) begin
        if (lat_cnt >= 2) begin
          mem_data = line_of(mem_pc);
          mem_done = 1'b1;
          refills.push_back(mem_pc);
          lat_cnt = 0;
        end else lat_cnt++;
      end else lat_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values and cold start
    start_phase();
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_pc", mem_pc, 0);
    chk("rst_inst_done", 32'(inst_done), 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_pre_j", 32'(inst_pre_j), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("cold_mem_en", 32'(mem_en), 1);
    chk("cold_mem_pc", mem_pc, 0);
    wait_obs(8, 40, "cold_timeout");
    for (int i = 0; i < 8; i++) begin
      chk("cold_pc", opc(i), 32'(i * 4));
      chk("cold_inst", oinst(i), addi(32'(i * 4)));
      chk("cold_pj", opj(i), 0);
      chk("cold_b2b", ocyc(i) - ocyc(0), 32'(i));
    end

    // Back-pressure: queue fills, nothing leaves, then drains in order
    start_phase();
    rob_full = 1'b1; rst = 1'b0;
    repeat (10) @(negedge clk);
    rs_full = 1'b1; rob_full = 1'b0;
    repeat (10) @(negedge clk);
    chk("stall_no_out", 32'(obs_pc.size()), 0);
    rs_full = 1'b0;
    wait_obs(8, 40, "stall_timeout");
    for (int i = 0; i < 8; i++) begin
      chk("stall_pc", opc(i), 32'(i * 4));
      chk("stall_b2b", ocyc(i) - ocyc(0), 32'(i));
    end

    // JAL at 0x8 -> 0x108
    start_phase();
    imem[2] = jal(32'h100);
    rst = 1'b0;
    wait_obs(4, 60, "jal_timeout");
    chk("jal_pc2", opc(2), 32'h8);
    chk("jal_inst", oinst(2), 32'h1000_006F);
    chk("jal_pj", opj(2), 1);
    chk("jal_pj1", opj(1), 0);
    chk("jal_target", opc(3), 32'h108);
    chk("jal_refill0", rfl(0), 32'h0);
    chk("jal_refill1", rfl(1), 32'h100);

    // LRU: 0x000, 0x400, 0x800 share set 0
    start_phase();
    imem[0]     = jal(32'h400);
    imem[256]   = jal(32'hFFFF_FC04);
    imem[1]     = jal(32'h7FC);
    imem[512]   = jal(32'hFFFF_F808);
    imem[2]     = jal(32'h3FC);
    rst = 1'b0;
    wait_obs(6, 80, "lru_timeout");
    chk("lru_pc1", opc(1), 32'h400);
    chk("lru_pc3", opc(3), 32'h800);
    chk("lru_pc4", opc(4), 32'h8);
    chk("lru_pc5", opc(5), 32'h404);
    chk("lru_refill2", rfl(2), 32'h800);
    chk("lru_refill3", rfl(3), 32'h400);
    chk("lru_nrefill", 32'(refills.size()), 4);

    // Predictor: train taken twice, then not-taken twice
    start_phase();
    imem[16] = beq(32'h80);
    rst = 1'b0; br_pre = 1'b1; br_pre_j = 1'b1; br_pre_pc = 32'h40;
    repeat (2) @(negedge clk);
    br_pre = 1'b0;
    wait_obs(18, 120, "pred_t_timeout");
    chk("pred_t_pc", opc(16), 32'h40);
    chk("pred_t_pj", opj(16), 1);
    chk("pred_t_next", opc(17), 32'hC0);
    rollback = 1'b1; br_res_pc = 32'h0; br_pre = 1'b1; br_pre_j = 1'b0;
    @(negedge clk);
    chk("pred_rb_flush", 32'(inst_done), 0);
    rollback = 1'b0;
    obs_pc.delete(); obs_inst.delete(); obs_pj.delete(); obs_cyc.delete();
    @(negedge clk);
    br_pre = 1'b0;
    wait_obs(18, 60, "pred_nt_timeout");
    chk("pred_nt_pc", opc(16), 32'h40);
    chk("pred_nt_pj", opj(16), 0);
    chk("pred_nt_next", opc(17), 32'h44);
    chk("pred_cached", ocyc(17) - ocyc(0), 17);

    // Rollback to 0x200 while the 0x100 refill is outstanding
    start_phase();
    imem[2] = jal(32'hF8);
    rob_full = 1'b1; rst = 1'b0;
    for (int k = 0; k < 40 && refills.size() < 1; k++) @(negedge clk);
    mem_stall = 1'b1;
    repeat (10) @(negedge clk);
    chk("rb_mem_en", 32'(mem_en), 1);
    chk("rb_mem_pc", mem_pc, 32'h100);
    chk("rb_held", 32'(obs_pc.size()), 0);
    rollback = 1'b1; br_res_pc = 32'h200; rob_full = 1'b0;
    @(negedge clk);
    chk("rb_no_pop", 32'(inst_done), 0);
    rollback = 1'b0;
    repeat (4) @(negedge clk);
    chk("rb_queue_empty", 32'(obs_pc.size()), 0);
    chk("rb_refill_kept", 32'(mem_en), 1);
    mem_stall = 1'b0;
    wait_obs(1, 40, "rb_timeout");
    chk("rb_first_pc", opc(0), 32'h200);
    chk("rb_refill1", rfl(1), 32'h100);
    chk("rb_refill2", rfl(2), 32'h200);
    rollback = 1'b1; br_res_pc = 32'h100;
    @(negedge clk);
    rollback = 1'b0; c0 = cyc;
    obs_pc.delete(); obs_inst.delete(); obs_pj.delete(); obs_cyc.delete();
    wait_obs(1, 20, "rb2_timeout");
    chk("rb_installed_pc", opc(0), 32'h100);
    chk("rb_installed_hit", ocyc(0) - 32'(c0), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
